// File: rtl/lda_polyline_sequencer_if.sv
// Vertex command stream into the polyline sequencer: valid/ready with one vertex per beat.
// The slave stalls the producer with cmd_ready low while its queue is full.
interface lda_polyline_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic        cmd_move;
  logic [15:0] cmd_color;
  logic [8:0]  cmd_thickness;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_move, cmd_color, cmd_thickness,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_move, cmd_color, cmd_thickness,
    output cmd_ready
  );
endinterface

// File: rtl/lda_polyline_sequencer.sv
// Generic synchronous FIFO with flush; read data is the registered head, visible same cycle.
// Pushes while full are dropped, flush clears the queue on the next edge and wins over push/pop.
module lda_fifo #(
  parameter int W      = 43,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [W-1:0]      wr_dat,
  output logic [W-1:0]      rd_dat,
  output logic [ADDR_W:0]   count
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && (count != FULL) && !flush;
  assign pop_ok  = pop && (count != '0) && !flush;
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Polyline front end for the LDA: one Go per line-to, pop-to-Go 2 cycles, >=5 cycles per segment.
// cmd_ready drops while the vertex FIFO is full; Done_from_LDA low holds off popping.
module lda_polyline_sequencer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  lda_polyline_sequencer_if.slave cmd,
  input  logic                    flush,
  input  logic                    Done_from_LDA,
  output logic                    Go_to_LDA,
  output logic [8:0]              X0_to_LDA,
  output logic [7:0]              Y0_to_LDA,
  output logic [8:0]              X1_to_LDA,
  output logic [7:0]              Y1_to_LDA,
  output logic [15:0]             Color_to_LDA,
  output logic [8:0]              Thickness,
  output logic                    busy,
  output logic [ADDR_W:0]         fifo_count,
  output logic [15:0]             lines_drawn
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic        move;
    logic [8:0]  thickness;
    logic [15:0] color;
    logic [7:0]  y;
    logic [8:0]  x;
  } vtx_t;

  typedef enum logic [2:0] {IDLE, DECODE, GO, SETTLE, WAIT} state_t;

  state_t state, state_nxt;
  vtx_t   wr_vtx, rd_vtx, cur;
  logic   push, pop;
  logic   pen_valid, flush_seen;
  logic   start_pen;

  assign cmd.cmd_ready = (fifo_count < FULL);
  assign push          = cmd.cmd_valid && cmd.cmd_ready && !flush;
  assign pop           = (state == IDLE) && (fifo_count != '0) && Done_from_LDA && !flush;
  assign wr_vtx        = {cmd.cmd_move, cmd.cmd_thickness, cmd.cmd_color, cmd.cmd_y, cmd.cmd_x};
  // Without a valid pen position a line-to can only place the pen.
  assign start_pen     = cur.move || !pen_valid;

  lda_fifo #(
    .W      ($bits(vtx_t)),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .wr_dat (wr_vtx),
    .rd_dat (rd_vtx),
    .count  (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Go_to_LDA = 1'b0;
    busy      = (state != IDLE) || (fifo_count != '0);
    case (state)
      IDLE:    if (pop) state_nxt = DECODE;
      DECODE:  state_nxt = (flush || start_pen) ? IDLE : GO;
      GO: begin
        Go_to_LDA = 1'b1;
        state_nxt = SETTLE;
      end
      SETTLE:  state_nxt = WAIT;
      WAIT:    if (Done_from_LDA) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur          <= '0;
      pen_valid    <= 1'b0;
      flush_seen   <= 1'b0;
      X0_to_LDA    <= '0;
      Y0_to_LDA    <= '0;
      X1_to_LDA    <= '0;
      Y1_to_LDA    <= '0;
      Color_to_LDA <= '0;
      Thickness    <= '0;
      lines_drawn  <= '0;
    end else begin
      if (pop) cur <= rd_vtx;
      case (state)
        DECODE: begin
          if (!flush && start_pen) begin
            X0_to_LDA <= cur.x;
            Y0_to_LDA <= cur.y;
            pen_valid <= 1'b1;
          end else if (!flush) begin
            X1_to_LDA    <= cur.x;
            Y1_to_LDA    <= cur.y;
            Color_to_LDA <= cur.color;
            Thickness    <= cur.thickness;
          end
        end
        WAIT: begin
          if (Done_from_LDA) begin
            X0_to_LDA   <= X1_to_LDA;
            Y0_to_LDA   <= Y1_to_LDA;
            lines_drawn <= lines_drawn + 16'd1;
            pen_valid   <= !(flush_seen || flush);
            flush_seen  <= 1'b0;
          end
        end
        default: ;
      endcase
      // A segment already handed to the LDA finishes, but must not leave the pen down.
      if (flush) begin
        pen_valid <= 1'b0;
        if (state == GO || state == SETTLE || (state == WAIT && !Done_from_LDA))
          flush_seen <= 1'b1;
      end
    end
  end
endmodule
